// File: rtl/serial_deserializer.sv
// Serial-to-parallel collector: assembles WIDTH-bit words from a strobed bit stream into a one-entry Valid/Rdy output register.
// Optional even-parity trailer bit enabled by defining SERIAL_DESERIALIZER_PARITY_EN.
module serial_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             En,
    input  logic             D,
    input  logic             Clr,
    input  logic             Rdy,
    output logic [WIDTH-1:0] Q,
    output logic             Valid,
    output logic             Busy,
    output logic             Overrun,
    output logic             ParErr
);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] sreg_reg, sreg_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             valid_reg, valid_next;
    logic             busy_reg;
    logic             overrun_reg, overrun_next;
    logic             parerr_reg, parerr_next;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             word_perr;
    logic             shift_en;
    logic             complete;

    // Wiring of the shift path: new bit enters at the LSB end (MSB-first) or the MSB end (LSB-first).
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_in
                assign shifted[gi] = D;
            end else begin : g_mid
                assign shifted[gi] = sreg_reg[gi-1];
            end
        end else begin : g_lsb
            if (gi == WIDTH - 1) begin : g_in
                assign shifted[gi] = D;
            end else begin : g_mid
                assign shifted[gi] = sreg_reg[gi+1];
            end
        end
    end

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    // The trailing parity bit is checked against the data already held in sreg and never shifted in.
    assign word      = sreg_reg;
    assign word_perr = (^sreg_reg) ^ D;
    assign shift_en  = (count_reg != CW'(WIDTH));
`else
    assign word      = shifted;
    assign word_perr = 1'b0;
    assign shift_en  = 1'b1;
`endif

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        sreg_next    = sreg_reg;
        q_next       = q_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;
        parerr_next  = parerr_reg;
        complete     = 1'b0;

        if (Clr) begin
            state_next   = IDLE;
            count_next   = '0;
            sreg_next    = '0;
            overrun_next = 1'b0;
        end else if (En) begin
            if (shift_en) begin
                sreg_next = shifted;
            end
            case (state_reg)
                IDLE: begin
                    count_next = CW'(1);
                    state_next = COLLECT;
                end
                default: begin
                    if (count_reg == LAST) begin
                        complete   = 1'b1;
                        count_next = '0;
                        state_next = IDLE;
                    end else begin
                        count_next = count_reg + CW'(1);
                    end
                end
            endcase
        end

        if (complete) begin
            if (!valid_reg || Rdy) begin
                q_next      = word;
                valid_next  = 1'b1;
                parerr_next = word_perr;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (valid_reg && Rdy) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            sreg_reg    <= '0;
            q_reg       <= '0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            parerr_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            sreg_reg    <= sreg_next;
            q_reg       <= q_next;
            valid_reg   <= valid_next;
            busy_reg    <= (count_next != '0);
            overrun_reg <= overrun_next;
            parerr_reg  <= parerr_next;
        end
    end

    assign Q       = q_reg;
    assign Valid   = valid_reg;
    assign Busy    = busy_reg;
    assign Overrun = overrun_reg;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    assign ParErr  = parerr_reg;
`else
    assign ParErr  = 1'b0;
`endif

endmodule
